// File: rtl/rw_bank_arbiter.sv
// Round-robin arbiter in front of a small flop-based read/write word bank.
// Locked bursts hold one requester for up to MAX_BURST beats; the whole bank image is exported.
module rw_bank_arbiter #(
    parameter int NREQ      = 3,
    parameter int DW        = 11,
    parameter int ROWS      = 2,
    parameter int COLS      = 4,
    parameter int MAX_BURST = 4,
    parameter int AW        = $clog2(ROWS*COLS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           req_we,
    input  logic [NREQ-1:0]           req_lock,
    input  logic [NREQ*AW-1:0]        req_addr,
    input  logic [NREQ*DW-1:0]        req_wdata,
    output logic [NREQ-1:0]           gnt,
    output logic                      rsp_valid,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [DW-1:0]             rsp_rdata,
    output logic [ROWS*COLS*DW-1:0]   bank,
    output logic                      err_addr
);
    localparam int WORDS = ROWS * COLS;
    localparam int IDW   = $clog2(NREQ);
    localparam int MW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CW    = $clog2(MAX_BURST + 1);

    typedef enum logic {ST_ARB, ST_BURST} state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    owner_q, owner_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DW-1:0]     mem_q [WORDS];
    logic [DW-1:0]     mem_d [WORDS];
    logic              rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;
    logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic              err_q, err_d;

    logic [AW-1:0]     addr_arr  [NREQ];
    logic [DW-1:0]     wdata_arr [NREQ];
    logic [NREQ-1:0]   gnt_vec;
    logic              gnt_any;
    logic [IDW-1:0]    gnt_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*AW +: AW];
            assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
        end
        for (gi = 0; gi < WORDS; gi++) begin : g_bank
            assign bank[gi*DW +: DW] = mem_q[gi];
        end
    endgenerate

    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] k);
        return (k == IDW'(NREQ - 1)) ? '0 : k + IDW'(1);
    endfunction

    always_comb begin
        logic [IDW-1:0] cand;
        logic [AW-1:0]  k_addr;
        logic [MW-1:0]  widx;
        logic           in_range;

        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        mem_d       = mem_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_rdata_d = rsp_rdata_q;
        err_d       = err_q;
        gnt_vec     = '0;
        gnt_any     = 1'b0;
        gnt_idx     = '0;
        cand        = '0;
        k_addr      = '0;
        widx        = '0;
        in_range    = 1'b0;

        // Burst owner excludes everyone else; otherwise scan from the pointer with wrap.
        if (state_q == ST_BURST) begin
            gnt_any = req[owner_q];
            gnt_idx = owner_q;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                cand = IDW'((int'(ptr_q) + i) % NREQ);
                if (!gnt_any && req[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
        gnt_vec[gnt_idx] = gnt_any;

        if (gnt_any) begin
            k_addr   = addr_arr[gnt_idx];
            widx     = MW'(k_addr);
            in_range = (int'(k_addr) < WORDS);
            if (!in_range) begin
                err_d = 1'b1;
            end
            if (req_we[gnt_idx]) begin
                if (in_range) begin
                    mem_d[widx] = wdata_arr[gnt_idx];
                end
            end else begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = gnt_idx;
                rsp_rdata_d = in_range ? mem_q[widx] : '0;
            end
        end

        case (state_q)
            ST_ARB: begin
                if (gnt_any) begin
                    if (req_lock[gnt_idx] && (MAX_BURST > 1)) begin
                        state_d = ST_BURST;
                        owner_d = gnt_idx;
                        cnt_d   = CW'(1);
                    end else begin
                        ptr_d = next_idx(gnt_idx);
                    end
                end
            end
            ST_BURST: begin
                if (gnt_any && req_lock[owner_q] && (int'(cnt_q) + 1 < MAX_BURST)) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    // Burst ends by unlock, beat limit, or the owner abandoning its request.
                    state_d = ST_ARB;
                    ptr_d   = next_idx(owner_q);
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ARB;
            ptr_q       <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            mem_q       <= '{default: '0};
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            mem_q       <= mem_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_q       <= err_d;
        end
    end

    assign gnt       = gnt_vec;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_rdata = rsp_rdata_q;
    assign err_addr  = err_q;

endmodule

// File: tb/tb_rw_bank_arbiter.sv
// Randomized and directed bench for rw_bank_arbiter against a transaction-level reference model.
// A second instance with a 1x4 bank exercises the out-of-range address path.
module tb_rw_bank_arbiter;
    localparam int NREQ  = 3;
    localparam int DW    = 11;
    localparam int WORDS = 8;
    localparam int MAXB  = 4;

    logic         clk;
    logic         rst;
    logic [2:0]   req, req_we, req_lock;
    logic [2:0]   a_addr [3];
    logic [10:0]  a_wd   [3];
    logic [8:0]   req_addr;
    logic [32:0]  req_wdata;
    logic [2:0]   gnt;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic [10:0]  rsp_rdata;
    logic [87:0]  bank;
    logic         err_addr;

    logic [2:0]   s_req, s_req_we, s_req_lock;
    logic [8:0]   s_req_addr;
    logic [32:0]  s_req_wdata;
    logic [2:0]   s_gnt;
    logic         s_rsp_valid;
    logic [1:0]   s_rsp_id;
    logic [10:0]  s_rsp_rdata;
    logic [43:0]  s_bank;
    logic         s_err_addr;

    assign req_addr  = {a_addr[2], a_addr[1], a_addr[0]};
    assign req_wdata = {a_wd[2], a_wd[1], a_wd[0]};

    rw_bank_arbiter u_dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid),
        .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .bank(bank), .err_addr(err_addr)
    );

    rw_bank_arbiter #(.ROWS(1), .AW(3)) u_dut_small (
        .clk(clk), .rst(rst), .req(s_req), .req_we(s_req_we), .req_lock(s_req_lock),
        .req_addr(s_req_addr), .req_wdata(s_req_wdata), .gnt(s_gnt), .rsp_valid(s_rsp_valid),
        .rsp_id(s_rsp_id), .rsp_rdata(s_rsp_rdata), .bank(s_bank), .err_addr(s_err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ntx      = 0;

    // Reference model: arbitration pointer, burst owner (-1 = none), beat count, word store.
    int           m_ptr;
    int           m_owner;
    int           m_cnt;
    logic [10:0]  m_mem [WORDS];
    bit           m_err;
    bit           m_rv;
    int           m_rid;
    logic [10:0]  m_rdata;

    logic [2:0] gobs;
    logic [2:0] exp3 [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [2:0] exp4 [6] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b001};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_owner = -1; m_cnt = 0; m_err = 0; m_rv = 0; m_rid = 0; m_rdata = '0;
        for (int i = 0; i < WORDS; i++) m_mem[i] = '0;
    endtask

    function automatic int exp_grant();
        if (m_owner >= 0) return req[m_owner] ? m_owner : -1;
        for (int i = 0; i < NREQ; i++) begin
            if (req[(m_ptr + i) % NREQ]) return (m_ptr + i) % NREQ;
        end
        return -1;
    endfunction

    // Called at a falling edge with inputs applied; checks, then advances one clock.
    task automatic step(output logic [2:0] g_seen);
        int          g;
        int          a;
        logic [87:0] img;
        #1;
        g = exp_grant();
        g_seen = gnt;
        chk("gnt", gnt, (g < 0) ? 128'd0 : (128'd1 << g));
        chk("rsp_valid", rsp_valid, m_rv);
        if (m_rv) begin
            chk("rsp_id", rsp_id, m_rid);
            chk("rsp_rdata", rsp_rdata, m_rdata);
        end
        for (int i = 0; i < WORDS; i++) img[i*DW +: DW] = m_mem[i];
        chk("bank", bank, img);
        chk("err_addr", err_addr, m_err);
        $display("txn %0d req=%b lock=%b we=%b gnt=%b rsp_valid=%b", ntx, req, req_lock, req_we, gnt, rsp_valid);
        ntx++;

        m_rv = 0;
        if (g >= 0) begin
            a = int'(a_addr[g]);
            if (a >= WORDS) begin
                m_err = 1;
                if (!req_we[g]) begin m_rv = 1; m_rid = g; m_rdata = '0; end
            end else if (req_we[g]) begin
                m_mem[a] = a_wd[g];
            end else begin
                m_rv = 1; m_rid = g; m_rdata = m_mem[a];
            end
        end
        if (m_owner < 0) begin
            if (g >= 0) begin
                if (req_lock[g] && MAXB > 1) begin m_owner = g; m_cnt = 1; end
                else m_ptr = (g + 1) % NREQ;
            end
        end else if (g >= 0 && req_lock[g] && m_cnt + 1 < MAXB) begin
            m_cnt++;
        end else begin
            m_ptr = (m_owner + 1) % NREQ;
            m_owner = -1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        req = '0; req_we = '0; req_lock = '0;
        for (int i = 0; i < 3; i++) begin a_addr[i] = '0; a_wd[i] = '0; end
        s_req = '0; s_req_we = '0; s_req_lock = '0; s_req_addr = '0; s_req_wdata = '0;
        model_reset();
        #2;
        chk("rst_gnt", gnt, 3'b000);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_id", rsp_id, 2'd0);
        chk("rst_rsp_rdata", rsp_rdata, 11'd0);
        chk("rst_bank", bank, 88'd0);
        chk("rst_err", err_addr, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Write then read back word 5 from requester 0.
        req = 3'b001; req_we = 3'b001; a_addr[0] = 3'd5; a_wd[0] = 11'h7AB;
        step(gobs); chk("t2_gnt_wr", gobs, 3'b001);
        req_we = 3'b000;
        step(gobs); chk("t2_gnt_rd", gobs, 3'b001);
        chk("t2_rsp_valid", rsp_valid, 1'b1);
        chk("t2_rsp_id", rsp_id, 2'd0);
        chk("t2_rsp_rdata", rsp_rdata, 11'h7AB);
        chk("t2_bank5", bank[5*11 +: 11], 11'h7AB);

        // Align pointer to 0, then all three requesting without locks.
        req = 3'b100; a_addr[2] = 3'd0;
        step(gobs);
        req = 3'b111; a_addr[0] = 3'd1; a_addr[1] = 3'd2;
        for (int i = 0; i < 6; i++) begin
            step(gobs); chk("t3_gnt_seq", gobs, exp3[i]);
        end

        // Move pointer to 1, then requester 1 holds a locked burst.
        req = 3'b001;
        step(gobs);
        req = 3'b111; req_lock = 3'b010;
        for (int i = 0; i < 6; i++) begin
            step(gobs); chk("t4_gnt_seq", gobs, exp4[i]);
        end
        req_lock = 3'b000;

        // Requester 2: store word 6, read word 7 (zero) and word 6 back-to-back.
        req = 3'b100; req_we = 3'b100; a_addr[2] = 3'd6; a_wd[2] = 11'h123;
        step(gobs);
        req_we = 3'b000; a_addr[2] = 3'd7;
        step(gobs);
        chk("t5_rv_a", rsp_valid, 1'b1);
        chk("t5_id_a", rsp_id, 2'd2);
        chk("t5_data_a", rsp_rdata, 11'd0);
        a_addr[2] = 3'd6;
        step(gobs);
        chk("t5_rv_b", rsp_valid, 1'b1);
        chk("t5_id_b", rsp_id, 2'd2);
        chk("t5_data_b", rsp_rdata, 11'h123);

        for (int n = 0; n < 300; n++) begin
            req      = 3'($urandom_range(0, 7));
            req_we   = 3'($urandom_range(0, 7));
            req_lock = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
            for (int i = 0; i < 3; i++) begin
                a_addr[i] = 3'($urandom_range(0, 7));
                a_wd[i]   = 11'($urandom_range(0, 2047));
            end
            step(gobs);
        end

        // Out-of-range read and write on the 4-word instance.
        s_req = 3'b001; s_req_we = 3'b000; s_req_addr = 9'b000_000_111;
        #1;
        chk("t6_gnt", s_gnt, 3'b001);
        chk("t6_err_before", s_err_addr, 1'b0);
        @(posedge clk); @(negedge clk);
        chk("t6_rsp_valid", s_rsp_valid, 1'b1);
        chk("t6_rsp_id", s_rsp_id, 2'd0);
        chk("t6_rsp_rdata", s_rsp_rdata, 11'd0);
        chk("t6_err_set", s_err_addr, 1'b1);
        s_req_we = 3'b001; s_req_wdata = {22'd0, 11'h3FF};
        @(posedge clk); @(negedge clk);
        s_req = 3'b000; s_req_we = 3'b000;
        repeat (3) @(negedge clk);
        chk("t6_bank_untouched", s_bank, 44'd0);
        chk("t6_err_sticky", s_err_addr, 1'b1);
        chk("t6_rsp_idle", s_rsp_valid, 1'b0);

        // Async reset in the middle of a locked write burst.
        req = 3'b000; req_lock = 3'b000; req_we = 3'b000;
        step(gobs);
        req = 3'b010; req_lock = 3'b010; req_we = 3'b010; a_addr[1] = 3'd2; a_wd[1] = 11'h555;
        step(gobs);
        step(gobs);
        chk("t1_bank_pre", bank[2*11 +: 11], 11'h555);
        rst = 1'b1;
        #1;
        chk("t1_bank_clr", bank, 88'd0);
        chk("t1_rsp_valid", rsp_valid, 1'b0);
        chk("t1_rsp_id", rsp_id, 2'd0);
        chk("t1_rsp_rdata", rsp_rdata, 11'd0);
        chk("t1_err", err_addr, 1'b0);
        chk("t1_small_err_clr", s_err_addr, 1'b0);
        @(posedge clk); @(negedge clk);
        req = 3'b111; req_lock = 3'b000; req_we = 3'b000;
        rst = 1'b0;
        model_reset();
        step(gobs); chk("t1_first_gnt", gobs, 3'b001);
        step(gobs);
        step(gobs);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
